// File: rtl/multi_speed_tick_gen.sv
// Multi-channel velocity tick generator. Each channel picks a target period from its
// power-up, curse and energy inputs, then ramps its live period toward it one wrap at a time.
module multi_speed_tick_gen #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ENERGY_W    = 11,
  parameter int unsigned ENERGY_LOW  = 3,
  parameter int unsigned PERIOD_FAST = 757_575,
  parameter int unsigned PERIOD_NORM = 925_925,
  parameter int unsigned PERIOD_SLOW = 1_111_110,
  parameter int unsigned CURSE_NUM   = 5,
  parameter int unsigned CURSE_DEN   = 4,
  parameter int unsigned RAMP_STEP   = 65_536
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          power_up_active,
  input  logic [CHANNELS-1:0]          curse_active,
  input  logic [CHANNELS*ENERGY_W-1:0] energy,
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          velocity_clk,
  output logic [CHANNELS-1:0]          at_target,
  output logic [CHANNELS*CNT_W-1:0]    period_cur
);

  localparam int unsigned XW = CNT_W + 4;

  // Curse periods use 4 guard bits so the multiply cannot overflow before the divide.
  localparam logic [XW-1:0] CURSE_NORM_X =
    (XW'(PERIOD_NORM) * XW'(CURSE_NUM)) / XW'(CURSE_DEN);
  localparam logic [XW-1:0] CURSE_SLOW_X =
    (XW'(PERIOD_SLOW) * XW'(CURSE_NUM)) / XW'(CURSE_DEN);

  localparam logic [CNT_W-1:0]    P_FAST  = CNT_W'(PERIOD_FAST);
  localparam logic [CNT_W-1:0]    P_NORM  = CNT_W'(PERIOD_NORM);
  localparam logic [CNT_W-1:0]    P_SLOW  = CNT_W'(PERIOD_SLOW);
  localparam logic [CNT_W-1:0]    P_CNORM = CURSE_NORM_X[CNT_W-1:0];
  localparam logic [CNT_W-1:0]    P_CSLOW = CURSE_SLOW_X[CNT_W-1:0];
  localparam logic [CNT_W-1:0]    STEP    = CNT_W'(RAMP_STEP);
  localparam logic [ENERGY_W-1:0] E_LOW   = ENERGY_W'(ENERGY_LOW);

  function automatic logic [CNT_W-1:0] target_sel(
    input logic                pu,
    input logic                cu,
    input logic [ENERGY_W-1:0] e
  );
    logic [CNT_W-1:0] res;
    res = (e > E_LOW) ? (cu ? P_CNORM : P_NORM) : (cu ? P_CSLOW : P_SLOW);
    if (pu) res = P_FAST;
    return res;
  endfunction

  // The direction is picked by magnitude compare so the difference never wraps.
  function automatic logic [CNT_W-1:0] ramp_next(
    input logic [CNT_W-1:0] cur,
    input logic [CNT_W-1:0] tgt
  );
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] res;
    if (tgt >= cur) begin
      diff = tgt - cur;
      res  = (RAMP_STEP == 0 || diff <= STEP) ? tgt : cur + STEP;
    end else begin
      diff = cur - tgt;
      res  = (RAMP_STEP == 0 || diff <= STEP) ? tgt : cur - STEP;
    end
    return res;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic             r_tick;
    logic             r_vclk;
    logic [CNT_W-1:0] w_tgt;

    assign w_tgt = target_sel(power_up_active[g], curse_active[g],
                              energy[g*ENERGY_W +: ENERGY_W]);

    always_ff @(posedge sysclk) begin
      if (reset) begin
        r_cnt  <= '0;
        r_per  <= P_NORM;
        r_tick <= 1'b0;
        r_vclk <= 1'b0;
      end else if (en[g]) begin
        // >= rather than == so a period that shrinks below the count still wraps at once.
        if (r_cnt >= r_per) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_vclk <= ~r_vclk;
          r_per  <= ramp_next(r_per, w_tgt);
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign tick[g]                      = r_tick;
    assign velocity_clk[g]              = r_vclk;
    assign period_cur[g*CNT_W +: CNT_W] = r_per;
    assign at_target[g]                 = (r_per == w_tgt);
  end

endmodule

// File: doc/multi_speed_tick_gen.md
Name: multi_speed_tick_gen

Overview:
- Parametrised, multi-channel velocity-tick generator.
- Drives movement timing for the player and N-1 enemy/projectile entities.
- Each channel selects a target period from its power-up, curse and energy inputs.
- The channel ramps its live period toward that target in bounded steps (acceleration/deceleration), then emits a one-cycle tick and a toggled velocity clock for its movement FSM.

Parameters:
CHANNELS, 4, number of independent channels
CNT_W, 32, period/counter width
ENERGY_W, 11, per-channel energy width
ENERGY_LOW, 3, energy at or below this selects slow base period
PERIOD_FAST, 757_575, power-up period in cycles (22 Hz / 3-phase)
PERIOD_NORM, 925_925, normal period (18 Hz / 3-phase)
PERIOD_SLOW, 1_111_110, low-energy period (15 Hz / 3-phase)
CURSE_NUM, 5, curse multiplier numerator
CURSE_DEN, 4, curse multiplier denominator
RAMP_STEP, 65_536, maximum period change per tick; 0 = immediate

Ports:
sysclk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  CHANNELS  per-channel run enable
power_up_active  in  CHANNELS  per-channel boost request
curse_active  in  CHANNELS  per-channel curse request
energy  in  CHANNELS*ENERGY_W  per-channel energy, channel i at bits [i*ENERGY_W +: ENERGY_W]
tick  out  CHANNELS  one-cycle pulse per period
velocity_clk  out  CHANNELS  toggles on every tick
at_target  out  CHANNELS  1 when live period equals target period
period_cur  out  CHANNELS*CNT_W  live period per channel, same packing as energy

Behaviour:
- Reset (synchronous, sysclk only):
  - count=0, tick=0, velocity_clk=0, period_cur=PERIOD_NORM on all channels.
  - at_target is combinational and reflects period_cur vs target.
  - Reset overrides en and any in-progress ramp.
- Target period (combinational, per channel). Curse constants are elaboration-time, computed as P*CURSE_NUM/CURSE_DEN with floor, in CNT_W+4 bits, then truncated to CNT_W.
  - power_up_active=1: PERIOD_FAST. Power-up wins over curse and ignores energy.
  - else base = (energy > ENERGY_LOW) ? PERIOD_NORM : PERIOD_SLOW.
  - curse_active=1 (and no power-up): base scaled by the curse constant.
  - otherwise: base.
- Counter (per channel, en=1):
  - If count >= period_cur: count<=0, tick<=1, velocity_clk<=~velocity_clk, ramp update applied.
  - Else count<=count+1, tick<=0.
  - Using >= guarantees a wrap within one cycle if period_cur shrinks below count.
  - Tick spacing is period_cur+1 cycles, using the period_cur in effect before the wrap.
  - First tick after reset occurs on the (PERIOD_NORM+1)th enabled cycle.
- Ramp (applied only on wrap cycles):
  - diff = target − period_cur.
  - If RAMP_STEP=0 or |diff| <= RAMP_STEP: period_cur<=target.
  - Else period_cur moves by ±RAMP_STEP toward target.
  - Comparisons are unsigned with no wrap-around; the subtraction direction is chosen by magnitude compare.
  - Target changes mid-ramp take effect at the next wrap.
- en=0: count, period_cur and velocity_clk hold; tick=0. Re-enabling resumes from the held count.
- Channels are fully independent. No shared state; a simultaneous wrap on all channels is legal.
- Inputs are sampled synchronously. No input synchronisers inside; callers provide sysclk-domain signals.

Test Plan:
- Shared setup: CHANNELS=2, PERIOD_FAST=5, PERIOD_NORM=9, PERIOD_SLOW=11, CURSE 5/4 (curse NORM=11, curse SLOW=13), ENERGY_LOW=3.
- Reset, then RAMP_STEP=0, en=1, energy=10, no modes -> tick every 10 cycles, first at cycle 10. velocity_clk toggles each tick. at_target=1. period_cur=9.
- RAMP_STEP=0, energy=3, curse_active=1 -> after first wrap period_cur=13, ticks every 14 cycles. Energy→4 gives period_cur=11 after next wrap.
- RAMP_STEP=2, power_up_active 0→1 from period 9 -> period_cur 7, then 5 on successive ticks. at_target=0 until 5. Release gives 7 then 9.
- power_up_active=1 and curse_active=1 with energy=0 -> target 5; power-up wins.
- en=0 for 20 cycles mid-count (count=4) -> tick stays 0, count/velocity_clk/period_cur unchanged. Resumes and wraps after 5 more cycles at period 9.
- Channel 0 power-up, channel 1 cursed: periods 5 and 11 coexist. Assert reset mid-ramp -> next cycle both channels have count=0, tick=0, velocity_clk=0, period_cur=9.
